// File: rtl/rc4_encrypt_writer.sv
// RC4 encrypt writer: INIT/KSA/PRGA over a single-port 256x8 S RAM; ciphertext byte k = f XOR pt[k].
// Optional keystream tap (ks_byte/ks_valid) is enabled by defining RC4_KS_TAP_EN.
module rc4_encrypt_writer #(
   parameter int MSG_LEN = 32,
   parameter int ADDR_W  = 5
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [23:0]       secret_key,
   output logic [ADDR_W-1:0] pt_addr,
   input  logic [7:0]        pt_data,
   output logic [ADDR_W-1:0] ct_addr,
   output logic [7:0]        ct_data,
   output logic              ct_wren,
   output logic              busy,
   output logic              done
`ifdef RC4_KS_TAP_EN
   ,
   output logic [7:0]        ks_byte,
   output logic [0:0]        ks_valid
`endif
);

   typedef enum logic [3:0] {
      S_IDLE, S_INIT,
      S_K_RD_I, S_K_RD_J, S_K_SW_I, S_K_SW_J,
      S_P_RD_I, S_P_RD_J, S_P_SW_I, S_P_SW_J, S_P_RD_F, S_P_WRITE,
      S_DONE
   } state_t;

   localparam logic [ADDR_W-1:0] LAST_K = ADDR_W'(MSG_LEN - 1);

   state_t            state_q;
   logic [7:0]        i_q, j_q, si_q, sj_q;
   logic [ADDR_W-1:0] k_q;
   logic [23:0]       key_q;
   logic [1:0]        ksel_q;
   logic [ADDR_W-1:0] pt_addr_q, ct_addr_q;
   logic [7:0]        ct_data_q;
   logic              ct_wren_q, busy_q, done_q;

   logic [7:0] s_mem [256];
   logic [7:0] ram_rdata_q;
   logic       ram_we;
   logic [7:0] ram_addr, ram_wdata;
   logic [7:0] key_byte, j_d, i_inc;

   assign i_inc = i_q + 8'd1;

   always_comb begin
      case (ksel_q)
         2'd0:    key_byte = key_q[23:16];
         2'd1:    key_byte = key_q[15:8];
         default: key_byte = key_q[7:0];
      endcase
   end

   always_comb begin
      case (state_q)
         S_K_RD_J: j_d = j_q + ram_rdata_q + key_byte;
         S_P_RD_J: j_d = j_q + ram_rdata_q;
         default:  j_d = j_q;
      endcase
   end

   // Single-port S: every state issues at most one access; reads return next cycle.
   always_comb begin
      ram_we    = 1'b0;
      ram_addr  = i_q;
      ram_wdata = i_q;
      case (state_q)
         S_INIT:               ram_we = 1'b1;
         S_K_RD_J, S_P_RD_J:   ram_addr = j_d;
         S_K_SW_I, S_P_SW_I: begin
            ram_we    = 1'b1;
            ram_wdata = ram_rdata_q;
         end
         S_K_SW_J, S_P_SW_J: begin
            ram_we    = 1'b1;
            ram_addr  = j_q;
            ram_wdata = si_q;
         end
         S_P_RD_I:             ram_addr = i_inc;
         S_P_RD_F:             ram_addr = si_q + sj_q;
         default:              ram_addr = i_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (ram_we) s_mem[ram_addr] <= ram_wdata;
      ram_rdata_q <= s_mem[ram_addr];
   end

`ifdef RC4_KS_TAP_EN
   logic [7:0] ks_byte_q;
   logic       ks_valid_q;
   assign ks_byte  = ks_byte_q;
   assign ks_valid = ks_valid_q;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_IDLE;
         i_q       <= '0;
         j_q       <= '0;
         k_q       <= '0;
         si_q      <= '0;
         sj_q      <= '0;
         key_q     <= '0;
         ksel_q    <= '0;
         pt_addr_q <= '0;
         ct_addr_q <= '0;
         ct_data_q <= '0;
         ct_wren_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
`ifdef RC4_KS_TAP_EN
         ks_byte_q  <= '0;
         ks_valid_q <= 1'b0;
`endif
      end else begin
         ct_wren_q <= 1'b0;
         done_q    <= 1'b0;
`ifdef RC4_KS_TAP_EN
         ks_valid_q <= 1'b0;
`endif
         case (state_q)
            // done_q high blocks acceptance so a new job starts the cycle after done
            S_IDLE: if (start && !done_q) begin
               key_q   <= secret_key;
               busy_q  <= 1'b1;
               i_q     <= '0;
               state_q <= S_INIT;
            end
            S_INIT: begin
               i_q <= i_inc;
               if (i_q == 8'hFF) begin
                  j_q     <= '0;
                  ksel_q  <= '0;
                  state_q <= S_K_RD_I;
               end
            end
            S_K_RD_I: state_q <= S_K_RD_J;
            S_K_RD_J: begin
               si_q    <= ram_rdata_q;
               j_q     <= j_d;
               state_q <= S_K_SW_I;
            end
            S_K_SW_I: begin
               sj_q    <= ram_rdata_q;
               state_q <= S_K_SW_J;
            end
            S_K_SW_J: begin
               i_q    <= i_inc;
               ksel_q <= (ksel_q == 2'd2) ? 2'd0 : ksel_q + 2'd1;
               if (i_q == 8'hFF) begin
                  j_q     <= '0;
                  k_q     <= '0;
                  state_q <= S_P_RD_I;
               end else begin
                  state_q <= S_K_RD_I;
               end
            end
            S_P_RD_I: begin
               i_q       <= i_inc;
               pt_addr_q <= k_q;
               state_q   <= S_P_RD_J;
            end
            S_P_RD_J: begin
               si_q    <= ram_rdata_q;
               j_q     <= j_d;
               state_q <= S_P_SW_I;
            end
            S_P_SW_I: begin
               sj_q    <= ram_rdata_q;
               state_q <= S_P_SW_J;
            end
            S_P_SW_J: state_q <= S_P_RD_F;
            S_P_RD_F: state_q <= S_P_WRITE;
            S_P_WRITE: begin
               ct_addr_q <= k_q;
               ct_data_q <= ram_rdata_q ^ pt_data;
               ct_wren_q <= 1'b1;
`ifdef RC4_KS_TAP_EN
               ks_byte_q  <= ram_rdata_q;
               ks_valid_q <= 1'b1;
`endif
               if (k_q == LAST_K) begin
                  state_q <= S_DONE;
               end else begin
                  k_q     <= k_q + 1'b1;
                  state_q <= S_P_RD_I;
               end
            end
            S_DONE: begin
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign pt_addr = pt_addr_q;
   assign ct_addr = ct_addr_q;
   assign ct_data = ct_data_q;
   assign ct_wren = ct_wren_q;
   assign busy    = busy_q;
   assign done    = done_q;

endmodule
